// File: rtl/game_state_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : game_pkg
// Brief    : Shared state encoding and BCD score constants for game control.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int c_bcd_digit_w = 4;
  localparam int c_bcd_digits  = 4;
  localparam int c_score_w     = c_bcd_digit_w * c_bcd_digits;
  localparam logic [c_bcd_digit_w-1:0] c_bcd_max = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CRASH = 2'd2,
    OVER  = 2'd3
  } state_t;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_state_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : game_state_ctrl_if
// Brief    : Video/button inputs and overlay/score outputs of the game FSM.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface game_state_ctrl_if;
  import game_pkg::*;

  logic                 refr_tick;
  logic                 video_on;
  logic                 car_on;
  logic                 obst_on;
  logic                 btn_start;
  logic                 game_run;
  logic                 crash_en;
  logic                 crash_pulse;
  logic [c_score_w-1:0] score;
  logic [1:0]           state;

  modport master (
    output refr_tick, video_on, car_on, obst_on, btn_start,
    input  game_run, crash_en, crash_pulse, score, state
  );

  modport slave (
    input  refr_tick, video_on, car_on, obst_on, btn_start,
    output game_run, crash_en, crash_pulse, score, state
  );
endinterface
`default_nettype wire

// File: rtl/game_state_ctrl_score_bcd_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : score_bcd_counter
// Brief    : Four-digit BCD incrementer, sync clear, saturating at 9999.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module score_bcd_counter
  import game_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 clr,
  input  wire logic                 inc,
  output logic      [c_score_w-1:0] bcd
);

  logic [c_score_w-1:0]  r_bcd;
  logic [c_score_w-1:0]  w_next;
  logic [c_bcd_digits:0] w_carry;
  logic                  w_sat;

  assign w_carry[0] = 1'b1;

  for (genvar gi = 0; gi < c_bcd_digits; gi++) begin : g_digit
    logic [c_bcd_digit_w-1:0] w_d;
    assign w_d            = r_bcd[gi*c_bcd_digit_w +: c_bcd_digit_w];
    assign w_carry[gi+1]  = w_carry[gi] & (w_d == c_bcd_max);
    assign w_next[gi*c_bcd_digit_w +: c_bcd_digit_w] =
      !w_carry[gi]       ? w_d :
      (w_d == c_bcd_max) ? '0  : w_d + 1'b1;
  end

  // A carry out of the top digit means every digit is 9.
  assign w_sat = w_carry[c_bcd_digits];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
    end else if (clr) begin
      r_bcd <= '0;
    end else if (inc && !w_sat) begin
      r_bcd <= w_next;
    end
  end

  assign bcd = r_bcd;

endmodule
`default_nettype wire

// File: rtl/game_state_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : game_state_ctrl
// Brief    : Play/crash/game-over FSM driving the crash overlay and score.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int HOLD_FRAMES      = 60,
  parameter int BLINK_FRAMES     = 30,
  parameter int FRAMES_PER_POINT = 60
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  game_state_ctrl_if.slave bus
);

  localparam int c_frame_w = cnt_width(FRAMES_PER_POINT);
  localparam int c_hold_w  = cnt_width(HOLD_FRAMES);
  localparam int c_blink_w = cnt_width(BLINK_FRAMES);
  localparam logic [c_frame_w-1:0] c_frame_last = c_frame_w'(FRAMES_PER_POINT - 1);
  localparam logic [c_hold_w-1:0]  c_hold_last  = c_hold_w'(HOLD_FRAMES - 1);
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_FRAMES - 1);

  state_t               r_state;
  logic                 r_btn_d;
  logic                 r_hit;
  logic                 r_game_run;
  logic                 r_crash_en;
  logic                 r_crash_pulse;
  logic                 r_blink_ph;
  logic [c_frame_w-1:0] r_frame_cnt;
  logic [c_hold_w-1:0]  r_hold_cnt;
  logic [c_blink_w-1:0] r_blink_cnt;

  logic w_start_edge;
  logic w_hit;
  logic w_frame_hit;
  logic w_score_clr;
  logic w_score_inc;

  assign w_start_edge = bus.btn_start & ~r_btn_d;
  assign w_hit        = bus.video_on & bus.car_on & bus.obst_on & (r_state == PLAY);
  // A hit in the refr_tick cycle still belongs to the frame being closed.
  assign w_frame_hit  = r_hit | w_hit;
  assign w_score_clr  = w_start_edge & ((r_state == IDLE) | (r_state == OVER));
  assign w_score_inc  = (r_state == PLAY) & bus.refr_tick & ~w_frame_hit &
                        (r_frame_cnt == c_frame_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_btn_d       <= 1'b1;
      r_hit         <= 1'b0;
      r_game_run    <= 1'b0;
      r_crash_en    <= 1'b0;
      r_crash_pulse <= 1'b0;
      r_blink_ph    <= 1'b0;
      r_frame_cnt   <= '0;
      r_hold_cnt    <= '0;
      r_blink_cnt   <= '0;
    end else begin
      r_btn_d       <= bus.btn_start;
      r_crash_pulse <= 1'b0;

      if (bus.refr_tick) begin
        r_hit <= 1'b0;
      end else if (w_hit) begin
        r_hit <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_start_edge) begin
            r_state     <= PLAY;
            r_game_run  <= 1'b1;
            r_frame_cnt <= '0;
            r_hit       <= 1'b0;
          end
        end

        PLAY: begin
          if (bus.refr_tick) begin
            if (w_frame_hit) begin
              r_state       <= CRASH;
              r_game_run    <= 1'b0;
              r_crash_en    <= 1'b1;
              r_crash_pulse <= 1'b1;
              r_frame_cnt   <= '0;
              r_hold_cnt    <= '0;
            end else if (r_frame_cnt == c_frame_last) begin
              r_frame_cnt <= '0;
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end

        CRASH: begin
          if (bus.refr_tick) begin
            if (r_hold_cnt == c_hold_last) begin
              r_state     <= OVER;
              r_blink_cnt <= '0;
              r_blink_ph  <= 1'b1;
              r_crash_en  <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
        end

        OVER: begin
          // Restart takes priority over a blink step in the same cycle.
          if (w_start_edge) begin
            r_state     <= PLAY;
            r_game_run  <= 1'b1;
            r_crash_en  <= 1'b0;
            r_frame_cnt <= '0;
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
            r_hit       <= 1'b0;
          end else if (bus.refr_tick) begin
            if (r_blink_cnt == c_blink_last) begin
              r_blink_cnt <= '0;
              r_blink_ph  <= ~r_blink_ph;
              r_crash_en  <= ~r_blink_ph;
            end else begin
              r_blink_cnt <= r_blink_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  score_bcd_counter u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_score_clr),
    .inc   (w_score_inc),
    .bcd   (bus.score)
  );

  assign bus.state       = r_state;
  assign bus.game_run    = r_game_run;
  assign bus.crash_en    = r_crash_en;
  assign bus.crash_pulse = r_crash_pulse;

endmodule
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_game_state_ctrl
// Brief    : Directed bench for game_state_ctrl with a frame-level reference model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_game_state_ctrl;

  localparam int HOLD  = 4;
  localparam int BLINK = 2;
  localparam int FPP   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  game_state_ctrl_if ifc ();

  game_state_ctrl #(
    .HOLD_FRAMES      (HOLD),
    .BLINK_FRAMES     (BLINK),
    .FRAMES_PER_POINT (FPP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0..3, score derived from collision-free frames played.
  int m_mode     = 0;
  bit m_btn_prev = 1'b1;
  bit m_hit_seen = 1'b0;
  int m_play     = 0;
  int m_crash    = 0;
  int m_over     = 0;
  bit m_pulse    = 1'b0;
  bit m_start;
  bit m_hit;
  bit m_coll;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] expected();
    int  pts;
    bit  en;
    pts = m_play / FPP;
    if (pts > 9999) pts = 9999;
    en = (m_mode == 2) || (m_mode == 3 && ((m_over / BLINK) % 2 == 0));
    return {11'd0, 2'(m_mode), (m_mode == 1), en, m_pulse, to_bcd(pts)};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_btn_prev = 1'b1; m_hit_seen = 1'b0;
      m_play = 0; m_crash = 0; m_over = 0; m_pulse = 1'b0;
    end else begin
      m_start    = ifc.btn_start && !m_btn_prev;
      m_btn_prev = ifc.btn_start;
      m_hit      = ifc.video_on && ifc.car_on && ifc.obst_on && (m_mode == 1);
      m_coll     = m_hit_seen || m_hit;
      m_pulse    = 1'b0;
      case (m_mode)
        0: if (m_start) begin m_mode = 1; m_play = 0; end
        1: if (ifc.refr_tick) begin
             if (m_coll) begin m_mode = 2; m_pulse = 1'b1; m_crash = 0; end
             else m_play++;
           end
        2: if (ifc.refr_tick) begin
             m_crash++;
             if (m_crash == HOLD) begin m_mode = 3; m_over = 0; end
           end
        default: if (m_start) begin m_mode = 1; m_play = 0; end
                 else if (ifc.refr_tick) m_over++;
      endcase
      if (ifc.refr_tick) m_hit_seen = 1'b0;
      else if (m_hit)    m_hit_seen = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("model", {11'd0, ifc.state, ifc.game_run, ifc.crash_en, ifc.crash_pulse, ifc.score},
        expected());
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      ifc.refr_tick = 1'b1; cyc(1);
      ifc.refr_tick = 1'b0; cyc(1);
    end
  endtask

  logic [5:0] blink_pat;

  initial begin
    ifc.refr_tick = 1'b0; ifc.video_on = 1'b0; ifc.car_on = 1'b0;
    ifc.obst_on   = 1'b0; ifc.btn_start = 1'b1;
    blink_pat = 6'b110011;
    cyc(3);
    chk("reset_state", 32'(ifc.state), 32'd0);
    chk("reset_score", 32'(ifc.score), 32'h0);
    chk("reset_outs", {ifc.game_run, ifc.crash_en, ifc.crash_pulse}, 32'd0);

    // Button held through reset must not start a game.
    rst_n = 1'b1; cyc(3);
    chk("held_btn_idle", 32'(ifc.state), 32'd0);
    ifc.btn_start = 1'b0; cyc(2);
    chk("release_idle", 32'(ifc.state), 32'd0);
    ifc.btn_start = 1'b1; cyc(1);
    chk("start_state", 32'(ifc.state), 32'd1);
    chk("start_run", 32'(ifc.game_run), 32'd1);
    chk("start_score", 32'(ifc.score), 32'h0);
    ifc.btn_start = 1'b0; cyc(1);

    frames(9);
    chk("score_9f", 32'(ifc.score), 32'h0003);
    frames(30);
    chk("score_bcd_carry", 32'(ifc.score), 32'h0013);

    // Overlap outside the visible area is not a collision.
    ifc.car_on = 1'b1; ifc.obst_on = 1'b1; cyc(1);
    ifc.car_on = 1'b0; ifc.obst_on = 1'b0; cyc(2);
    frames(1);
    chk("blank_no_crash", 32'(ifc.state), 32'd1);

    ifc.video_on = 1'b1; ifc.car_on = 1'b1; ifc.obst_on = 1'b1; cyc(1);
    ifc.video_on = 1'b0; ifc.car_on = 1'b0; ifc.obst_on = 1'b0; cyc(3);
    ifc.refr_tick = 1'b1; cyc(1); ifc.refr_tick = 1'b0;
    chk("crash_pulse", 32'(ifc.crash_pulse), 32'd1);
    chk("crash_state", 32'(ifc.state), 32'd2);
    chk("crash_en_run", {ifc.crash_en, ifc.game_run}, 32'b10);
    cyc(1);
    chk("crash_pulse_once", 32'(ifc.crash_pulse), 32'd0);
    chk("score_frozen", 32'(ifc.score), 32'h0013);

    ifc.btn_start = 1'b1; cyc(1);
    chk("start_in_crash", 32'(ifc.state), 32'd2);
    ifc.btn_start = 1'b0; cyc(1);

    frames(HOLD - 1);
    chk("hold_state", 32'(ifc.state), 32'd2);
    chk("hold_en", 32'(ifc.crash_en), 32'd1);
    ifc.refr_tick = 1'b1; cyc(1); ifc.refr_tick = 1'b0;
    chk("over_state", 32'(ifc.state), 32'd3);
    chk("blink_0", 32'(ifc.crash_en), 32'(blink_pat[5]));
    for (int i = 1; i < 6; i++) begin
      frames(1);
      chk($sformatf("blink_%0d", i), 32'(ifc.crash_en), 32'(blink_pat[5-i]));
    end

    // Restart coincident with a frame tick.
    ifc.btn_start = 1'b1; ifc.refr_tick = 1'b1; cyc(1);
    ifc.btn_start = 1'b0; ifc.refr_tick = 1'b0;
    chk("restart_state", 32'(ifc.state), 32'd1);
    chk("restart_score", 32'(ifc.score), 32'h0);
    chk("restart_en", 32'(ifc.crash_en), 32'd0);

    // Hit in the tick cycle closes the frame as a crash.
    frames(2);
    ifc.video_on = 1'b1; ifc.car_on = 1'b1; ifc.obst_on = 1'b1; ifc.refr_tick = 1'b1; cyc(1);
    ifc.video_on = 1'b0; ifc.car_on = 1'b0; ifc.obst_on = 1'b0; ifc.refr_tick = 1'b0;
    chk("tick_hit_state", 32'(ifc.state), 32'd2);
    chk("tick_hit_pulse", 32'(ifc.crash_pulse), 32'd1);

    frames(HOLD);
    chk("over_again", 32'(ifc.state), 32'd3);
    ifc.btn_start = 1'b1; cyc(1); ifc.btn_start = 1'b0;
    chk("replay", 32'(ifc.state), 32'd1);

    ifc.refr_tick = 1'b1; cyc(29997); ifc.refr_tick = 1'b0; cyc(1);
    chk("score_9999", 32'(ifc.score), 32'h9999);
    ifc.refr_tick = 1'b1; cyc(5); ifc.refr_tick = 1'b0; cyc(1);
    chk("score_saturate", 32'(ifc.score), 32'h9999);
    chk("still_play", 32'(ifc.state), 32'd1);

    // Asynchronous reset away from a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", 32'(ifc.state), 32'd0);
    chk("async_outs", {ifc.game_run, ifc.crash_en, ifc.crash_pulse}, 32'd0);
    chk("async_score", 32'(ifc.score), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("post_reset_idle", 32'(ifc.state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Upstream controller for the "Crash" text overlay: runs the play/crash/game-over state machine and produces that overlay's `enable` (`crash_en`).
- Detects car/obstacle pixel collision within a frame.
- Holds the crash display, then blinks the text until restart.
- Keeps a 4-digit BCD survival score for the score renderer.

Parameters:
- HOLD_FRAMES, 60: frames `crash_en` is held steady after a crash before blinking starts.
- BLINK_FRAMES, 30: frames per blink half-period in OVER.
- FRAMES_PER_POINT, 60: PLAY frames per score increment.

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- refr_tick  in  1  one-cycle pulse per frame, in vertical blank
- video_on  in  1  pixel in visible area
- car_on  in  1  current pixel belongs to the player car
- obst_on  in  1  current pixel belongs to an obstacle
- btn_start  in  1  debounced start button, level
- game_run  out  1  1 while in PLAY; freezes car/obstacle motion when 0
- crash_en  out  1  enable to the "Crash" text overlay
- crash_pulse  out  1  one-cycle pulse on the PLAY->CRASH transition
- score  out  16  4 BCD digits, [15:12] most significant
- state  out  2  current state encoding

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; game_run, crash_en, crash_pulse = 0; score=0.
  - All counters and hit latch = 0.
  - btn_d (button history) = 1, so a button held through reset does not start a game.
- start_edge = btn_start & ~btn_d; btn_d registered every cycle.
- hit = video_on & car_on & obst_on & (state==PLAY).
  - hit_r is set by hit and cleared on refr_tick.
  - Frame collision = hit_r | hit, so a hit in the refr_tick cycle belongs to the closing frame.
- All outputs are registered; each transition is visible on outputs the cycle after the triggering edge.
- IDLE:
  - Outputs 0.
  - start_edge -> PLAY; clears score, frame_cnt, hit_r.
- PLAY:
  - game_run=1, crash_en=0.
  - On refr_tick with frame collision -> CRASH; crash_pulse=1 for one cycle; frame_cnt=0.
  - On refr_tick without collision: frame_cnt+1.
    - At FRAMES_PER_POINT-1: frame_cnt wraps to 0 and score increments BCD (9->0 carry per digit).
    - Score saturates at 9999; no wrap to 0000.
  - start_edge ignored.
- CRASH:
  - game_run=0, crash_en=1 steady; score frozen.
  - Counts refr_ticks; on the HOLD_FRAMES-th tick -> OVER with blink_cnt=0, blink_ph=1.
  - start_edge ignored.
- OVER:
  - crash_en=blink_ph.
  - Every BLINK_FRAMES refr_ticks blink_ph toggles.
  - start_edge -> PLAY; clears score, counters, hit_r.
  - crash_en=0 the cycle after.
- Simultaneous start_edge and refr_tick in OVER: start wins; no blink toggle is applied.
- Reset mid-game: immediate return to IDLE values; no crash_pulse.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.

Decomposition:
- Shared package game_pkg:
  - state typedef/localparams IDLE=2'd0, PLAY=2'd1, CRASH=2'd2, OVER=2'd3
  - BCD digit width constant
- Sub-module score_bcd_counter:
  - 4-digit BCD incrementer with sync clear and saturation at 9999.
  - Ports: clk, rst_n, clr, inc, bcd[15:0].

Test Plan (HOLD_FRAMES=4, BLINK_FRAMES=2, FRAMES_PER_POINT=3):
- Reset with btn_start=1 held, release, press again -> no PLAY until the second rising edge; then state=1, game_run=1, score=0x0000.
- PLAY for 9 collision-free frames -> score=0x0003; 30 more -> 0x0013, proving BCD carry 9->10.
- Preload score 0x9999 via 29997 frames, or force the sub-module -> further increments keep 0x9999.
- Single-cycle car_on&obst_on&video_on mid-frame, then refr_tick:
  - crash_pulse one cycle; state=2, crash_en=1, game_run=0.
  - Same stimulus with video_on=0 -> no crash.
- Hit coincident with refr_tick -> crash taken at that tick.
- After crash:
  - crash_en=1 for 4 ticks, then state=3.
  - crash_en pattern over subsequent ticks: 1,1,0,0,1,1.
  - start_edge during CRASH ignored.
- start_edge in OVER in the same cycle as refr_tick:
  - state=1, score=0, crash_en=0 next cycle.
  - Async reset mid-PLAY -> all outputs 0 immediately.
